// File: rtl/opb_pkg.sv
// Shared OPB definitions for the PPC-to-fabric register bank: bus widths, ack state,
// write payload and the OPB big-endian to user little-endian bit mapping helpers.
package opb_pkg;

    localparam int unsigned OPB_AWIDTH  = 32;
    localparam int unsigned OPB_DWIDTH  = 32;
    localparam int unsigned OPB_BEWIDTH = OPB_DWIDTH / 8;
    localparam int unsigned MAX_REGS    = 16;
    localparam int unsigned IDX_W       = 4;

    typedef logic [OPB_DWIDTH-1:0] bank_reg_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ack_state_t;

    // Write payload already remapped to user bit order
    typedef struct packed {
        bank_reg_t mask;
        bank_reg_t data;
    } wr_req_t;

    // OPB bit 0 (MSB) lands on user bit 31
    function automatic bank_reg_t opb_to_user(input logic [0:OPB_DWIDTH-1] d);
        bank_reg_t u;
        for (int unsigned k = 0; k < OPB_DWIDTH; k++) begin
            u[OPB_DWIDTH-1-k] = d[k];
        end
        return u;
    endfunction

    // BE[0] covers DBus[0:7], i.e. user bits [31:24]
    function automatic bank_reg_t be_to_mask(input logic [0:OPB_BEWIDTH-1] be);
        bank_reg_t m;
        for (int unsigned j = 0; j < OPB_BEWIDTH; j++) begin
            m[OPB_DWIDTH-1-8*j -: 8] = {8{be[j]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/opb_register_ppc2simulink_bank_if.sv
// OPB slave-side bus bundle for the PPC-to-fabric register bank.
interface opb_register_ppc2simulink_bank_if;
    import opb_pkg::*;

    logic [0:OPB_AWIDTH-1]  OPB_ABus;
    logic [0:OPB_BEWIDTH-1] OPB_BE;
    logic [0:OPB_DWIDTH-1]  OPB_DBus;
    logic                   OPB_RNW;
    logic                   OPB_select;
    logic                   OPB_seqAddr;

    logic [0:OPB_DWIDTH-1]  Sl_DBus;
    logic                   Sl_xferAck;
    logic                   Sl_errAck;
    logic                   Sl_retry;
    logic                   Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

endinterface

// File: rtl/opb_slave_decode.sv
// OPB address decode and single-cycle ack generation; produces per-register write
// enables, a read strobe and the byte-merged write payload.
module opb_slave_decode
    import opb_pkg::*;
#(
    parameter logic [31:0]  C_BASEADDR   = 32'h0100_8200,
    parameter logic [31:0]  C_HIGHADDR   = 32'h0100_82FF,
    parameter int unsigned  C_OPB_AWIDTH = 32,
    parameter int unsigned  C_NUM_REGS   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [0:OPB_AWIDTH-1]  abus,
    input  logic [0:OPB_BEWIDTH-1] be,
    input  logic [0:OPB_DWIDTH-1]  dbus,
    input  logic                   rnw,
    input  logic                   select,
    input  logic                   seq_addr,
    output logic                   ack_q,
    output logic [C_NUM_REGS-1:0]  we_c,
    output logic                   rd_c,
    output logic [IDX_W-1:0]       idx_c,
    output wr_req_t                wr_c
);

    localparam int unsigned AW = C_OPB_AWIDTH;

    ack_state_t    state_q, state_d;
    logic [AW-1:0] addr_c, offset_c, word_c;
    logic          hit_c, in_range_c, xfer_c, wr_go_c;
    logic          unused_c;

    assign unused_c = seq_addr;

    always_comb begin
        addr_c     = AW'(abus);
        offset_c   = addr_c - AW'(C_BASEADDR);
        word_c     = offset_c >> 2;
        hit_c      = select && (addr_c >= AW'(C_BASEADDR)) && (addr_c <= AW'(C_HIGHADDR));
        in_range_c = (word_c < AW'(C_NUM_REGS));
        idx_c      = IDX_W'(word_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // A hit in IDLE acks next cycle; the ack cycle always returns to IDLE
    always_comb begin
        state_d = state_q;
        xfer_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hit_c) begin
                    state_d = ST_ACK;
                    xfer_c  = 1'b1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign ack_q = (state_q == ST_ACK);

    always_comb begin
        wr_go_c = xfer_c && !rnw && (|be) && in_range_c;
        rd_c    = xfer_c && rnw && in_range_c;
        we_c    = '0;
        for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
            we_c[i] = wr_go_c && (word_c == AW'(i));
        end
        wr_c.mask = be_to_mask(be);
        wr_c.data = opb_to_user(dbus);
    end

endmodule

// File: rtl/opb_register_ppc2simulink_bank.sv
// PPC-writable 32-bit control register bank on OPB with per-register update strobes.
// Define OPB_P2S_READBACK_EN to return register contents on reads; otherwise reads ack with zero data.
module opb_register_ppc2simulink_bank
    import opb_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR    = 32'h0100_8200,
    parameter logic [31:0] C_HIGHADDR    = 32'h0100_82FF,
    parameter int unsigned C_OPB_AWIDTH  = 32,
    parameter int unsigned C_OPB_DWIDTH  = 32,
    parameter int unsigned C_NUM_REGS    = 4,
    parameter logic [31:0] C_RESET_VALUE = 32'h0
) (
    input  logic                             OPB_Clk,
    input  logic                             OPB_Rst_n,
    opb_register_ppc2simulink_bank_if.slave  opb,
    output logic [32*C_NUM_REGS-1:0]         user_data_out,
    output logic [C_NUM_REGS-1:0]            user_update
);

    localparam int unsigned DW = C_OPB_DWIDTH;

    bank_reg_t             regs_q [C_NUM_REGS];
    bank_reg_t             regs_d [C_NUM_REGS];
    logic [C_NUM_REGS-1:0] we_c;
    logic [C_NUM_REGS-1:0] user_update_q, user_update_d;
    logic                  ack_q, rd_c;
    logic [IDX_W-1:0]      idx_c;
    wr_req_t               wr_c;

    opb_slave_decode #(
        .C_BASEADDR   (C_BASEADDR),
        .C_HIGHADDR   (C_HIGHADDR),
        .C_OPB_AWIDTH (C_OPB_AWIDTH),
        .C_NUM_REGS   (C_NUM_REGS)
    ) u_decode (
        .clk      (OPB_Clk),
        .rst_n    (OPB_Rst_n),
        .abus     (opb.OPB_ABus),
        .be       (opb.OPB_BE),
        .dbus     (opb.OPB_DBus),
        .rnw      (opb.OPB_RNW),
        .select   (opb.OPB_select),
        .seq_addr (opb.OPB_seqAddr),
        .ack_q    (ack_q),
        .we_c     (we_c),
        .rd_c     (rd_c),
        .idx_c    (idx_c),
        .wr_c     (wr_c)
    );

    // Byte-lane merge: enabled lanes take new data, others hold
    always_comb begin
        for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
            regs_d[i] = we_c[i] ? ((regs_q[i] & ~wr_c.mask) | (wr_c.data & wr_c.mask))
                                : regs_q[i];
        end
        user_update_d = we_c;
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
                regs_q[i] <= bank_reg_t'(C_RESET_VALUE);
            end
            user_update_q <= '0;
        end else begin
            regs_q        <= regs_d;
            user_update_q <= user_update_d;
        end
    end

`ifdef OPB_P2S_READBACK_EN
    bank_reg_t rdata_q, rdata_d;

    // Read data is only non-zero in the ack cycle of an in-range read
    always_comb begin
        rdata_d = '0;
        for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
            if (rd_c && (idx_c == IDX_W'(i))) rdata_d = regs_q[i];
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) rdata_q <= '0;
        else            rdata_q <= rdata_d;
    end

    assign opb.Sl_DBus = rdata_q;
`else
    logic unused_c;
    assign unused_c    = ^{rd_c, idx_c};
    assign opb.Sl_DBus = '0;
`endif

    always_comb begin
        user_data_out = '0;
        for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
            user_data_out[DW*i +: DW] = regs_q[i];
        end
    end

    assign user_update    = user_update_q;
    assign opb.Sl_xferAck = ack_q;
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_ppc2simulink_bank.sv
// Self-checking bench for opb_register_ppc2simulink_bank: directed table, corner sequences
// and random transfers against a byte-level register model.
module tb_opb_register_ppc2simulink_bank;

    localparam logic [31:0] BASE    = 32'h0100_8200;
    localparam logic [31:0] HIGH    = 32'h0100_82FF;
    localparam logic [31:0] RST_VAL = 32'hA5A5_0000;
    localparam int          NREG    = 4;
`ifdef OPB_P2S_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    opb_register_ppc2simulink_bank_if bus();
    logic [32*NREG-1:0] user_data_out;
    logic [NREG-1:0]    user_update;

    opb_register_ppc2simulink_bank #(
        .C_BASEADDR    (BASE),
        .C_HIGHADDR    (HIGH),
        .C_OPB_AWIDTH  (32),
        .C_OPB_DWIDTH  (32),
        .C_NUM_REGS    (NREG),
        .C_RESET_VALUE (RST_VAL)
    ) dut (
        .OPB_Clk       (clk),
        .OPB_Rst_n     (rst_n),
        .opb           (bus.slave),
        .user_data_out (user_data_out),
        .user_update   (user_update)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] model [NREG];

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic        rnw;
        logic        exp_ack;
        logic [31:0] exp_rd;
        logic [3:0]  exp_upd;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] img();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < NREG; i++) r[32*i +: 32] = model[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) model[i] = RST_VAL;
    endtask

    // Reference behaviour: byte k of the value is lane BE[3-k] of OPB
    task automatic model_xfer(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data,
                              input logic rnw, output logic ack, output logic [31:0] rd,
                              output logic [3:0] upd);
        int unsigned idx;
        ack = (addr >= BASE) && (addr <= HIGH);
        rd  = '0;
        upd = '0;
        if (ack) begin
            idx = (addr - BASE) / 4;
            if (idx < NREG) begin
                if (rnw) begin
                    rd = RB ? model[idx] : 32'h0;
                end else if (be != 4'b0) begin
                    for (int k = 0; k < 4; k++)
                        if (be[k]) model[idx][8*k +: 8] = data[8*k +: 8];
                    upd[idx] = 1'b1;
                end
            end
        end
    endtask

    task automatic bus_idle();
        bus.OPB_select = 1'b0;
        bus.OPB_ABus   = '0;
        bus.OPB_BE     = '0;
        bus.OPB_DBus   = '0;
        bus.OPB_RNW    = 1'b0;
    endtask

    task automatic run_xfer(input string name, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] data, input logic rnw, input logic exp_ack,
                            input logic [31:0] exp_rd, input logic [3:0] exp_upd);
        bus.OPB_ABus   = addr;
        bus.OPB_BE     = be;
        bus.OPB_DBus   = data;
        bus.OPB_RNW    = rnw;
        bus.OPB_select = 1'b1;
        chk({name, ".ack_pre"}, 128'(bus.Sl_xferAck), 128'(1'b0));
        step();
        chk({name, ".ack"}, 128'(bus.Sl_xferAck), 128'(exp_ack));
        chk({name, ".dbus"}, 128'(bus.Sl_DBus), 128'(exp_rd));
        chk({name, ".upd"}, 128'(user_update), 128'(exp_upd));
        chk({name, ".regs"}, user_data_out, img());
        bus_idle();
        step();
        chk({name, ".ack_post"}, 128'(bus.Sl_xferAck), 128'(1'b0));
        chk({name, ".dbus_post"}, 128'(bus.Sl_DBus), 128'(1'b0));
        chk({name, ".upd_post"}, 128'(user_update), 128'(1'b0));
    endtask

    initial begin
        vec_t        tab [12];
        logic        m_ack;
        logic [31:0] m_rd;
        logic [3:0]  m_upd;
        logic [31:0] a, d;
        logic [3:0]  b;
        logic        r;

        tab[0]  = '{"w_full",    BASE + 32'h4,  4'b1111, 32'h1234_5678, 1'b0, 1'b1, 32'h0,         4'b0010};
        tab[1]  = '{"w_lane1",   BASE + 32'h4,  4'b0100, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0,         4'b0010};
        tab[2]  = '{"r_reg1",    BASE + 32'h4,  4'b0000, 32'h0,         1'b1, 1'b1, 32'h12FF_5678, 4'b0000};
        tab[3]  = '{"w_oor",     BASE + 32'h40, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0,         4'b0000};
        tab[4]  = '{"w_nobe",    BASE + 32'h8,  4'b0000, 32'h1111_1111, 1'b0, 1'b1, 32'h0,         4'b0000};
        tab[5]  = '{"w_miss_hi", HIGH + 32'h1,  4'b1111, 32'h2222_2222, 1'b0, 1'b0, 32'h0,         4'b0000};
        tab[6]  = '{"w_miss_lo", BASE - 32'h4,  4'b1111, 32'h3333_3333, 1'b0, 1'b0, 32'h0,         4'b0000};
        tab[7]  = '{"w_lowbits", BASE + 32'hF,  4'b0001, 32'h0000_00CC, 1'b0, 1'b1, 32'h0,         4'b1000};
        tab[8]  = '{"r_reg3",    BASE + 32'hC,  4'b1111, 32'h0,         1'b1, 1'b1, 32'hA5A5_00CC, 4'b0000};
        tab[9]  = '{"r_oor",     BASE + 32'hFC, 4'b1111, 32'h0,         1'b1, 1'b1, 32'h0,         4'b0000};
        tab[10] = '{"r_reg0",    BASE,          4'b0000, 32'h0,         1'b1, 1'b1, 32'hA5A5_0000, 4'b0000};
        tab[11] = '{"r_miss",    HIGH + 32'h1,  4'b1111, 32'h0,         1'b1, 1'b0, 32'h0,         4'b0000};

        bus_idle();
        bus.OPB_seqAddr = 1'b0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.regs", user_data_out, img());
        chk("rst.ack", 128'(bus.Sl_xferAck), 128'(1'b0));
        chk("rst.upd", 128'(user_update), 128'(1'b0));
        chk("rst.dbus", 128'(bus.Sl_DBus), 128'(1'b0));
        chk("rst.tied", 128'({bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}), 128'(3'b000));
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed table
        for (int i = 0; i < 12; i++) begin
            model_xfer(tab[i].addr, tab[i].be, tab[i].data, tab[i].rnw, m_ack, m_rd, m_upd);
            run_xfer(tab[i].name, tab[i].addr, tab[i].be, tab[i].data, tab[i].rnw,
                     tab[i].exp_ack, RB ? tab[i].exp_rd : 32'h0, tab[i].exp_upd);
        end

        // Held select: ack, gap, re-ack as a fresh write
        bus.OPB_ABus   = BASE;
        bus.OPB_BE     = 4'b1111;
        bus.OPB_DBus   = 32'h0BAD_F00D;
        bus.OPB_RNW    = 1'b0;
        bus.OPB_select = 1'b1;
        model_xfer(BASE, 4'b1111, 32'h0BAD_F00D, 1'b0, m_ack, m_rd, m_upd);
        step();
        chk("held.ack1", 128'(bus.Sl_xferAck), 128'(1'b1));
        chk("held.upd1", 128'(user_update), 128'(4'b0001));
        chk("held.regs", user_data_out, img());
        step();
        chk("held.gap", 128'(bus.Sl_xferAck), 128'(1'b0));
        chk("held.gap_upd", 128'(user_update), 128'(4'b0000));
        step();
        chk("held.ack3", 128'(bus.Sl_xferAck), 128'(1'b1));
        chk("held.upd3", 128'(user_update), 128'(4'b0001));
        bus_idle();
        step();
        chk("held.end", 128'(bus.Sl_xferAck), 128'(1'b0));

        // Async reset asserted during the ack cycle
        bus.OPB_ABus   = BASE + 32'h8;
        bus.OPB_BE     = 4'b1111;
        bus.OPB_DBus   = 32'h5555_AAAA;
        bus.OPB_RNW    = 1'b0;
        bus.OPB_select = 1'b1;
        step();
        chk("rstmid.ack", 128'(bus.Sl_xferAck), 128'(1'b1));
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rstmid.ack_drop", 128'(bus.Sl_xferAck), 128'(1'b0));
        chk("rstmid.upd", 128'(user_update), 128'(1'b0));
        chk("rstmid.regs", user_data_out, img());
        bus_idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rstmid.after", user_data_out, img());

        // Random transfers against the model
        for (int n = 0; n < 200; n++) begin
            a = BASE - 32'h10 + 32'($urandom_range(0, 32'h120));
            b = 4'($urandom);
            d = $urandom;
            r = 1'($urandom);
            model_xfer(a, b, d, r, m_ack, m_rd, m_upd);
            run_xfer($sformatf("rnd%0d", n), a, b, d, r, m_ack, m_rd, m_upd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
